// File: rtl/reset_gen_pkg.sv
// Shared definitions for the reset generator: FSM states, reset-cause codes
// and the counter-width helper used by the top level and the debouncer.
package reset_gen_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT       = 2'd0,
      ST_WAIT_RELEASE = 2'd1,
      ST_RUN          = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;
   localparam logic [1:0] CAUSE_WDOG = 2'b11;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button conditioning: 2-flop synchronizer followed by a debouncer
// that accepts a new level after DEBOUNCE_CYCLES identical synchronized samples.
module btn_debounce
   import reset_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clock,
   input  logic rst_n,
   input  logic btn_n,
   output logic pressed
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [DW-1:0] cnt_q, cnt_d;

   // The count only runs while the synchronized input disagrees with the
   // accepted level, so any bounce back to the old level restarts it.
   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) level_d = sync2_q;
         else                  cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pressed = ~level_q;

endmodule

// File: rtl/reset_gen.sv
// System reset generator for the Z8S180 board: POR, debounced button, software
// and (with RESET_GEN_WDOG_EN defined) watchdog reset sources.
module reset_gen
   import reset_gen_pkg::*;
#(
   parameter int HOLD_CYCLES     = 16,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int WDOG_CYCLES     = 1000000
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       btn_n,
   input  logic       sw_req,
   input  logic       wdog_kick,
   output logic       cpu_rst_n,
   output logic [1:0] rst_cause
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    cause_q, cause_d;
   logic          cpu_rst_n_q, cpu_rst_n_d;
   logic          btn_pressed;
   logic          wdog_timeout;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clock   (clock),
      .rst_n   (rst_n),
      .btn_n   (btn_n),
      .pressed (btn_pressed)
   );

`ifdef RESET_GEN_WDOG_EN
   localparam int WW = cnt_width(WDOG_CYCLES);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

   logic [WW-1:0] wdog_q, wdog_d;

   assign wdog_timeout = (state_q == ST_RUN) && (wdog_q == WDOG_LAST);

   always_comb begin
      wdog_d = '0;
      if (state_q == ST_RUN && !wdog_kick && !wdog_timeout) wdog_d = wdog_q + 1'b1;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) wdog_q <= '0;
      else        wdog_q <= wdog_d;
   end
`else
   logic [1:0] unused_wdog;
   assign unused_wdog  = {wdog_kick, WDOG_CYCLES[0]};
   assign wdog_timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      cause_d     = cause_q;
      cpu_rst_n_d = cpu_rst_n_q;
      case (state_q)
         ST_ASSERT: begin
            cpu_rst_n_d = 1'b0;
            hold_d      = hold_q + 1'b1;
            if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               if (btn_pressed) begin
                  state_d = ST_WAIT_RELEASE;
               end else begin
                  state_d     = ST_RUN;
                  cpu_rst_n_d = 1'b1;
               end
            end
         end
         ST_WAIT_RELEASE: begin
            cpu_rst_n_d = 1'b0;
            if (!btn_pressed) begin
               state_d     = ST_RUN;
               cpu_rst_n_d = 1'b1;
            end
         end
         ST_RUN: begin
            cpu_rst_n_d = 1'b1;
            if (btn_pressed || wdog_timeout || sw_req) begin
               state_d     = ST_ASSERT;
               hold_d      = '0;
               cpu_rst_n_d = 1'b0;
               // Button wins over watchdog, watchdog over software.
               if (btn_pressed)       cause_d = CAUSE_BTN;
               else if (wdog_timeout) cause_d = CAUSE_WDOG;
               else                   cause_d = CAUSE_SW;
            end
         end
         default: begin
            state_d     = ST_ASSERT;
            hold_d      = '0;
            cpu_rst_n_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ASSERT;
         hold_q      <= '0;
         cause_q     <= CAUSE_POR;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         cause_q     <= cause_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   assign cpu_rst_n = cpu_rst_n_q;
   assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_gen.sv
// Scoreboard bench for reset_gen: each reset event pushes its expected
// low-pulse length and cause; a monitor measures every cpu_rst_n pulse.
module tb_reset_gen;
   import reset_gen_pkg::*;

   localparam int HOLD = 16;
   localparam int DEB  = 8;
   localparam int WDOG = 100;

   logic       clock = 1'b0;
   logic       rst_n, btn_n, sw_req, wdog_kick;
   logic       cpu_rst_n;
   logic [1:0] rst_cause;

   typedef struct {
      logic [1:0] cause;
      int         len;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   low_cnt = 0;

   always #5 clock = ~clock;

   reset_gen #(
      .HOLD_CYCLES     (HOLD),
      .DEBOUNCE_CYCLES (DEB),
      .WDOG_CYCLES     (WDOG)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .btn_n     (btn_n),
      .sw_req    (sw_req),
      .wdog_kick (wdog_kick),
      .cpu_rst_n (cpu_rst_n),
      .rst_cause (rst_cause)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // A clean button press of L samples keeps the CPU in reset for the
   // longer of the hold time and the time the button is held.
   function automatic int btn_len(input int l);
      return (l > HOLD) ? l : HOLD;
   endfunction

   // Monitor: length is counted only while rst_n is high, so an rst_n
   // pulse discards any partially measured pulse.
   always @(negedge clock) begin
      exp_t e;
      if (rst_n !== 1'b1) begin
         low_cnt <= 0;
      end else if (cpu_rst_n === 1'b0) begin
         low_cnt <= low_cnt + 1;
      end else if (low_cnt > 0) begin
         low_cnt <= 0;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got pulse len %0d cause %0d, required none",
                     low_cnt, rst_cause);
         end else begin
            e = sb.pop_front();
            check("pulse_len", low_cnt, e.len);
            check("pulse_cause", int'(rst_cause), int'(e.cause));
         end
      end
   end

   task automatic do_por(input int cycles);
      sb.delete();
      sb.push_back('{CAUSE_POR, HOLD});
      @(posedge clock); #1;
      rst_n = 1'b0;
      repeat (cycles) begin
         @(negedge clock);
         check("por_cpu_rst_n", int'(cpu_rst_n), 0);
         check("por_cause", int'(rst_cause), int'(CAUSE_POR));
      end
      @(posedge clock); #1;
      rst_n = 1'b1;
   endtask

   task automatic sw_pulse();
      @(posedge clock); #1;
      sw_req = 1'b1;
      @(posedge clock); #1;
      sw_req = 1'b0;
   endtask

   // Hold the button for l samples; optionally raise sw_req for one cycle
   // after sample sw_at (it is then seen by the DUT one edge later).
   task automatic press(input int l, input int sw_at);
      @(posedge clock); #1;
      btn_n = 1'b0;
      for (int i = 1; i <= l; i++) begin
         @(posedge clock); #1;
         sw_req = (i == sw_at);
      end
      btn_n  = 1'b1;
      sw_req = 1'b0;
   endtask

   task automatic bounce(input int l0, input int l1, input int l2);
      int lows[3];
      lows = '{l0, l1, l2};
      for (int b = 0; b < 3; b++) begin
         @(posedge clock); #1;
         btn_n = 1'b0;
         repeat (lows[b]) @(posedge clock);
         #1 btn_n = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clock);
      end
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((sb.size() != 0 || cpu_rst_n !== 1'b1) && n < max) begin
         @(negedge clock);
         n++;
      end
      check("idle_pending", sb.size(), 0);
      sb.delete();
      repeat (20) @(posedge clock);
   endtask

   initial begin
      int l, sw_at, cnt;
      rst_n     = 1'b0;
      btn_n     = 1'b1;
      sw_req    = 1'b0;
      wdog_kick = 1'b1;

      // Power-on reset
      do_por(5);
      wait_idle(100);

      // Long button press, released well after the hold time
      sb.push_back('{CAUSE_BTN, btn_len(40)});
      press(40, 0);
      wait_idle(200);

      // Short bouncy glitch must not reset
      bounce(2, 1, 2);
      wait_idle(100);

      // Software request, plus a repeat during the hold that must be ignored
      sb.push_back('{CAUSE_SW, HOLD});
      sw_pulse();
      repeat (5) @(posedge clock);
      sw_pulse();
      wait_idle(100);

      // Button and software request seen on the same edge: button wins
      sb.push_back('{CAUSE_BTN, btn_len(30)});
      press(30, 10);
      wait_idle(200);

      // Software request while waiting for button release is ignored
      sb.push_back('{CAUSE_BTN, btn_len(40)});
      press(40, 32);
      wait_idle(200);

      // rst_n pulse at hold count 7 restarts the sequence as POR
      sw_pulse();
      repeat (6) @(posedge clock);
      check("sw_cause_mid_hold", int'(rst_cause), int'(CAUSE_SW));
      do_por(2);
      wait_idle(100);

      // Randomized mix of events
      for (int it = 0; it < 14; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               sb.push_back('{CAUSE_SW, HOLD});
               sw_pulse();
            end
            1: begin
               l = $urandom_range(9, 40);
               sw_at = (l > 12 && $urandom_range(0, 1) == 1) ? $urandom_range(11, l - 1) : 0;
               sb.push_back('{CAUSE_BTN, btn_len(l)});
               press(l, sw_at);
            end
            2: bounce($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5));
            default: begin
               sb.push_back('{CAUSE_SW, HOLD});
               sw_pulse();
               repeat ($urandom_range(1, 11)) @(posedge clock);
               sw_pulse();
            end
         endcase
         wait_idle(200);
      end

      // Watchdog kicked every 50 clocks: never fires
      for (int r = 0; r < 6; r++) begin
         @(posedge clock); #1;
         wdog_kick = 1'b0;
         repeat (49) @(posedge clock);
         #1 wdog_kick = 1'b1;
      end
      @(negedge clock);
      check("wdog_kicked_no_reset", int'(cpu_rst_n), 1);

      // Watchdog left alone
      @(posedge clock); #1;
      wdog_kick = 1'b0;
      cnt = 0;
`ifdef RESET_GEN_WDOG_EN
      sb.push_back('{CAUSE_WDOG, HOLD});
      while (cpu_rst_n === 1'b1 && cnt < 300) begin
         @(negedge clock);
         if (cpu_rst_n === 1'b1) cnt++;
      end
      check("wdog_timeout_clocks", cnt, WDOG);
      wait_idle(100);
`else
      for (int i = 0; i < 3 * WDOG; i++) begin
         @(negedge clock);
         if (cpu_rst_n !== 1'b1) cnt++;
      end
      check("wdog_absent_low_cycles", cnt, 0);
`endif
      wdog_kick = 1'b1;

      wait_idle(100);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
